// File: rtl/run_ctrl.sv
// ---------------------------------------------------------------------------
// run_ctrl
//   Run controller sitting between the board/testbench clock-reset source and
//   the CPU core. It stretches reset towards the CPU for RST_CYCLES cycles and
//   gates CPU progress with a clock enable. Supports free-run and single-step
//   execution, a PC breakpoint, a CPU halt input and a cycle budget, and
//   reports why execution stopped.
//
// Ports
//   Clk      in   system clock, rising edge
//   Rst      in   synchronous active-high reset, highest priority
//   start    in   start/resume request (single-cycle pulse)
//   step     in   single-step request (single-cycle pulse)
//   mode     in   0 = free-run, 1 = single-step; sampled with start
//   halt_in  in   CPU halted (registered CPU output)
//   pc       in   current CPU program counter (registered CPU output)
//   bp_en    in   breakpoint enable
//   bp_addr  in   breakpoint address
//   cpu_rst  out  reset to the CPU, registered
//   cpu_en   out  CPU clock enable, combinational
//   cycles   out  number of cycles with cpu_en = 1, saturates at MAX_CYCLES
//   state    out  FSM state code (0 RST_HOLD, 1 IDLE, 2 RUN, 3 STEP, 4 STOP)
//   done     out  sticky terminal stop flag (budget or halt)
//   cause    out  stop cause: 00 none, 01 budget, 10 breakpoint, 11 halt
// ---------------------------------------------------------------------------
module run_ctrl #(
    parameter int PC_W       = 8,
    parameter int CNT_W      = 16,
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 100
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic             step,
    input  logic             mode,
    input  logic             halt_in,
    input  logic [PC_W-1:0]  pc,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    output logic             cpu_rst,
    output logic             cpu_en,
    output logic [CNT_W-1:0] cycles,
    output logic [2:0]       state,
    output logic             done,
    output logic [1:0]       cause
);

    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_IDLE     = 3'd1,
        ST_RUN      = 3'd2,
        ST_STEP     = 3'd3,
        ST_STOP     = 3'd4
    } state_t;

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_BUDGET = 2'b01;
    localparam logic [1:0] CAUSE_BP     = 2'b10;
    localparam logic [1:0] CAUSE_HALT   = 2'b11;

    // Hold counter must be able to reach RST_CYCLES itself.
    localparam int HOLD_W = (RST_CYCLES < 1) ? 1 : $clog2(RST_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_CYCLES);

    // Stop-cause encoding with fixed priority halt > breakpoint > budget.
    function automatic logic [1:0] stop_cause(input logic halt_hit,
                                              input logic bp_hit,
                                              input logic budget_hit);
        logic [1:0] c;
        if (halt_hit) begin
            c = CAUSE_HALT;
        end else if (bp_hit) begin
            c = CAUSE_BP;
        end else if (budget_hit) begin
            c = CAUSE_BUDGET;
        end else begin
            c = CAUSE_NONE;
        end
        return c;
    endfunction

    // Budget and halt stops can only be left through Rst.
    function automatic logic is_terminal(input logic [1:0] c);
        logic t;
        case (c)
            CAUSE_BUDGET: t = 1'b1;
            CAUSE_HALT:   t = 1'b1;
            default:      t = 1'b0;
        endcase
        return t;
    endfunction

    state_t              state_r;
    state_t              next_state_s;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic                cpu_rst_r;
    logic [CNT_W-1:0]    cycles_r;
    logic                done_r;
    logic [1:0]          cause_r;
    logic                mask_r;

    logic                bp_hit_s;
    logic                budget_hit_s;
    logic                stop_cond_s;
    logic [1:0]          stop_cause_s;
    logic                cpu_en_s;
    logic [1:0]          cause_next_s;
    logic                done_next_s;
    logic                mask_set_s;

    // Stop condition: the mask suppresses the breakpoint for the instruction
    // we resumed on, so that instruction executes exactly once.
    always_comb begin
        bp_hit_s     = bp_en & (pc == bp_addr) & ~mask_r;
        budget_hit_s = (cycles_r == MAX_C);
        stop_cond_s  = halt_in | bp_hit_s | budget_hit_s;
        stop_cause_s = stop_cause(halt_in, bp_hit_s, budget_hit_s);
    end

    // Next-state, stop-cause and clock-enable decode. start never reaches
    // cpu_en; its effect appears only through the registered state.
    always_comb begin
        next_state_s = state_r;
        cause_next_s = cause_r;
        done_next_s  = done_r;
        mask_set_s   = 1'b0;
        cpu_en_s     = 1'b0;
        case (state_r)
            ST_RST_HOLD: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RST_HOLD;
                end
            end
            ST_IDLE: begin
                if (start) begin
                    next_state_s = mode ? ST_STEP : ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                cpu_en_s = ~stop_cond_s;
                if (stop_cond_s) begin
                    next_state_s = ST_STOP;
                    cause_next_s = stop_cause_s;
                    done_next_s  = is_terminal(stop_cause_s);
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_STEP: begin
                cpu_en_s = step & ~stop_cond_s;
                // A start request takes precedence over a simultaneous step.
                if (start && !mode) begin
                    next_state_s = ST_RUN;
                end else if (step && stop_cond_s) begin
                    next_state_s = ST_STOP;
                    cause_next_s = stop_cause_s;
                    done_next_s  = is_terminal(stop_cause_s);
                end else begin
                    next_state_s = ST_STEP;
                end
            end
            ST_STOP: begin
                if ((cause_r == CAUSE_BP) && start) begin
                    next_state_s = mode ? ST_STEP : ST_RUN;
                    cause_next_s = CAUSE_NONE;
                    mask_set_s   = 1'b1;
                end else begin
                    next_state_s = ST_STOP;
                end
            end
            default: begin
                next_state_s = ST_RST_HOLD;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r <= ST_RST_HOLD;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Reset stretch: counter runs while Rst is low, cpu_rst drops once it
    // has counted RST_CYCLES cycles.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            hold_cnt_r <= {HOLD_W{1'b0}};
            cpu_rst_r  <= 1'b1;
        end else if ((state_r == ST_RST_HOLD) && (hold_cnt_r != HOLD_LAST)) begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
            cpu_rst_r  <= 1'b1;
        end else if (state_r == ST_RST_HOLD) begin
            hold_cnt_r <= hold_cnt_r;
            cpu_rst_r  <= 1'b0;
        end else begin
            hold_cnt_r <= hold_cnt_r;
            cpu_rst_r  <= cpu_rst_r;
        end
    end

    // Enabled-cycle counter, saturating at the budget.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cycles_r <= {CNT_W{1'b0}};
        end else if (cpu_en_s && (cycles_r != MAX_C)) begin
            cycles_r <= cycles_r + CNT_W'(1);
        end else begin
            cycles_r <= cycles_r;
        end
    end

    // Stop status and breakpoint mask; the mask lives until the first
    // enabled cycle after a breakpoint resume.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cause_r <= CAUSE_NONE;
            done_r  <= 1'b0;
            mask_r  <= 1'b0;
        end else begin
            cause_r <= cause_next_s;
            done_r  <= done_next_s;
            if (mask_set_s) begin
                mask_r <= 1'b1;
            end else if (cpu_en_s) begin
                mask_r <= 1'b0;
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    assign cpu_rst = cpu_rst_r;
    assign cpu_en  = cpu_en_s;
    assign cycles  = cycles_r;
    assign state   = state_r;
    assign done    = done_r;
    assign cause   = cause_r;

endmodule
